aes256_inv_key_stream: RTL and testbench

- Inverse AES-256 key schedule. Walks the expanded key backwards, for the decryption datapath.
- Loads the last two round keys (RK13, RK14) as one 256-bit window. Emits round keys in decryption order, RK14 down to RK0, one per output handshake.
- Sits between the key-expansion output (last-window tap) and the inverse-cipher round engine.
- Reuses the existing 4-byte sub_bytes S-box for the single S-box word per step.

---
 rtl/aes256_inv_key_stream.sv | 129 ++++++++++++
 tb/tb_aes256_inv_key_stream.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_inv_key_stream.sv
// Inverse AES-256 key schedule: loads the final {RK13, RK14} window and emits
// round keys RK14 down to RK0, one per yumi_i handshake.
module aes256_inv_key_stream #(
  parameter int unsigned num_rounds_p = 14
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  input  logic [255:0] key_i,
  output logic         ready_o,
  output logic         v_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         last_o,
  input  logic         yumi_i
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e       r_state, w_state_next;
  logic [127:0] r_hi, r_lo, w_hi_next, w_lo_next;
  logic [3:0]   r_idx, w_idx_next;

  logic [31:0]  w_hi0, w_hi1, w_hi2, w_hi3, w_lo3;
  logic [31:0]  w_t_in, w_t_out;
  logic [7:0]   w_rcon;
  logic [127:0] w_new_key;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, which maps 0 to 0) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Four-byte sub_bytes: one S-box per byte of the word.
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Word 0 of a round key occupies the most significant 32 bits.
  assign w_hi0 = r_hi[127:96];
  assign w_hi1 = r_hi[95:64];
  assign w_hi2 = r_hi[63:32];
  assign w_hi3 = r_hi[31:0];
  assign w_lo3 = r_lo[31:0];

  // Even idx steps cross a RotWord/rcon boundary of the forward schedule; odd ones
  // cross the AES-256 mid-block SubWord-only boundary.
  assign w_rcon  = 8'h01 << (r_idx[3:1] - 3'd1);
  assign w_t_in  = r_idx[0] ? w_lo3 : {w_lo3[23:0], w_lo3[31:24]};
  assign w_t_out = sub_word(w_t_in) ^ (r_idx[0] ? 32'h0 : {w_rcon, 24'h0});

  // RK(idx-2) from RK(idx) (hi) and the last word of RK(idx-1) (lo).
  assign w_new_key = {w_hi0 ^ w_t_out, w_hi1 ^ w_hi0, w_hi2 ^ w_hi1, w_hi3 ^ w_hi2};

  // Next-state logic: load in idle, step the window on each accepted key.
  always_comb begin
    w_state_next = r_state;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_idx_next   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (v_i) begin
          w_hi_next    = key_i[127:0];
          w_lo_next    = key_i[255:128];
          w_idx_next   = 4'(num_rounds_p);
          w_state_next = StEmit;
        end
      end
      StEmit: begin
        if (yumi_i) begin
          if (r_idx == 4'd0) begin
            w_state_next = StIdle;
          end else begin
            w_hi_next  = r_lo;
            w_idx_next = r_idx - 4'd1;
            if (r_idx >= 4'd2) w_lo_next = w_new_key;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and window registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= StIdle;
      r_hi    <= '0;
      r_lo    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_idx   <= w_idx_next;
    end
  end

  // Outputs decode registers only; no input-to-output path.
  always_comb begin
    ready_o  = (r_state == StIdle);
    v_o      = (r_state == StEmit);
    rk_o     = r_hi;
    rk_idx_o = r_idx;
    last_o   = (r_state == StEmit) && (r_idx == 4'd0);
  end

endmodule

// File: tb/tb_aes256_inv_key_stream.sv
// Directed bench for the inverse AES-256 key stream.
module tb_aes256_inv_key_stream;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic [255:0] key_i;
  logic         ready_o;
  logic         v_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         last_o;
  logic         yumi_i;

  int n_checks = 0;
  int n_fail   = 0;
  int walk_cycles;

  logic [31:0]  w      [0:59];
  logic [127:0] got_rk [0:14];
  logic         got_last [0:14];

  localparam logic [255:0] FipsKey =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FipsWin =
    {128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36};

  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes256_inv_key_stream #(.num_rounds_p(14)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .key_i    (key_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .rk_o     (rk_o),
    .rk_idx_o (rk_idx_o),
    .last_o   (last_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] tb_sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SboxTbl;
    return t[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] tb_sub_word(input logic [31:0] x);
    return {tb_sbox(x[31:24]), tb_sbox(x[23:16]), tb_sbox(x[15:8]), tb_sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] tb_rcon(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int j = 1; j < r; j++) v = {v[6:0], 1'b0};
    return v;
  endfunction

  function automatic logic [31:0] ks_temp(input int i, input logic [31:0] x);
    if (i % 8 == 0) return tb_sub_word({x[23:0], x[31:24]}) ^ {tb_rcon(i / 8), 24'h0};
    else if (i % 8 == 4) return tb_sub_word(x);
    else return x;
  endfunction

  function automatic logic [127:0] model_rk(input int i);
    return {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endfunction

  // Standard forward expansion of a 256-bit key into w[0..59].
  task automatic fwd_expand(input logic [255:0] k);
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) w[i] = w[i-8] ^ ks_temp(i, w[i-1]);
  endtask

  // Word-level inversion of the forward recurrence, starting from the last window.
  task automatic model_inv(input logic [255:0] win);
    for (int i = 0; i < 8; i++) w[52+i] = win[255 - 32*i -: 32];
    for (int i = 59; i >= 8; i--) w[i-8] = w[i] ^ ks_temp(i, w[i-1]);
  endtask

  task automatic load_key(input logic [255:0] k);
    int cyc;
    cyc = 0;
    while (ready_o !== 1'b1 && cyc < 50) begin
      @(posedge clk_i); #1; cyc++;
    end
    v_i = 1'b1;
    key_i = k;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    n_checks++;
    if (v_o !== 1'b1 || rk_idx_o !== 4'd14 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_latency: v_o=%b ready_o=%b rk_idx_o=%0d, required 1 0 14",
               v_o, ready_o, rk_idx_o);
    end
  endtask

  // Consume one walk; duty is the percent chance of yumi_i per cycle.
  task automatic run_walk(input int duty, input int busy_idx, input logic [255:0] busy_key);
    int n, cyc;
    logic stalled;
    logic [127:0] hold_rk;
    logic [3:0] hold_idx;
    n = 0; cyc = 0; stalled = 1'b0; hold_rk = '0; hold_idx = '0;
    while (n < 15 && cyc < 500) begin
      n_checks++;
      if (v_o !== 1'b1 || rk_idx_o !== 4'(14 - n)) begin
        n_fail++;
        $display("FAIL walk_seq: v_o=%b rk_idx_o=%0d, required v_o=1 rk_idx_o=%0d",
                 v_o, rk_idx_o, 14 - n);
        break;
      end
      if (stalled) begin
        n_checks++;
        if (rk_o !== hold_rk || rk_idx_o !== hold_idx) begin
          n_fail++;
          $display("FAIL stall_stable: rk_o=%h idx=%0d, required %h idx=%0d",
                   rk_o, rk_idx_o, hold_rk, hold_idx);
        end
      end
      got_rk[14-n]   = rk_o;
      got_last[14-n] = last_o;
      v_i = 1'b0;
      if (busy_idx >= 0 && (14 - n) == busy_idx) begin
        v_i = 1'b1;
        key_i = busy_key;
        n_checks++;
        if (ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready: ready_o=%b, required 0", ready_o);
        end
      end
      yumi_i   = ($urandom_range(0, 99) < duty);
      stalled  = !yumi_i;
      hold_rk  = rk_o;
      hold_idx = rk_idx_o;
      if (yumi_i) n++;
      @(posedge clk_i); #1;
      cyc++;
    end
    v_i = 1'b0;
    yumi_i = 1'b0;
    walk_cycles = cyc;
    n_checks++;
    if (n != 15) begin
      n_fail++;
      $display("FAIL walk_len: handshakes=%0d, required 15", n);
    end
    n_checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL walk_end: v_o=%b ready_o=%b, required 0 1", v_o, ready_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; key_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || rk_o !== 128'h0 || rk_idx_o !== 4'd0 ||
        last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b v=%b rk=%h idx=%0d last=%b, required 1 0 0 0 0",
               ready_o, v_o, rk_o, rk_idx_o, last_o);
    end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: ready=%b v=%b, required 1 0", ready_o, v_o);
    end
  endtask

  task automatic test_fips();
    fwd_expand(FipsKey);
    load_key(FipsWin);
    run_walk(100, -1, '0);
    n_checks++;
    if (walk_cycles != 15) begin
      n_fail++;
      $display("FAIL fips_cycles: cycles=%0d, required 15", walk_cycles);
    end
    n_checks++;
    if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      n_fail++;
      $display("FAIL fips_rk14: got %h, required 24fc79ccbf0979e9371ac23c6d68de36", got_rk[14]);
    end
    n_checks++;
    if (got_rk[13] !== 128'h4e5a6699a9f24fe07e572baacdf8cdea) begin
      n_fail++;
      $display("FAIL fips_rk13: got %h, required 4e5a6699a9f24fe07e572baacdf8cdea", got_rk[13]);
    end
    n_checks++;
    if (got_rk[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
      n_fail++;
      $display("FAIL fips_rk1: got %h, required 101112131415161718191a1b1c1d1e1f", got_rk[1]);
    end
    n_checks++;
    if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f || got_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_rk0: got %h last=%b, required 000102030405060708090a0b0c0d0e0f last=1",
               got_rk[0], got_last[0]);
    end
    for (int i = 1; i < 15; i++) begin
      n_checks++;
      if (got_last[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL fips_last_idx%0d: last_o=%b, required 0", i, got_last[i]);
      end
    end
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (got_rk[i] !== model_rk(i)) begin
        n_fail++;
        $display("FAIL fips_seq_idx%0d: got %h, required %h", i, got_rk[i], model_rk(i));
      end
    end
  endtask

  task automatic test_round_trip();
    logic [255:0] k;
    for (int t = 0; t < 20; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      fwd_expand(k);
      load_key({model_rk(13), model_rk(14)});
      run_walk(100, -1, '0);
      for (int i = 0; i < 15; i++) begin
        n_checks++;
        if (got_rk[i] !== model_rk(i)) begin
          n_fail++;
          $display("FAIL rt%0d_idx%0d: got %h, required %h", t, i, got_rk[i], model_rk(i));
        end
      end
      n_checks++;
      if ({got_rk[0], got_rk[1]} !== k) begin
        n_fail++;
        $display("FAIL rt%0d_key: got %h, required %h", t, {got_rk[0], got_rk[1]}, k);
      end
    end
  endtask

  task automatic test_backpressure();
    fwd_expand(FipsKey);
    load_key(FipsWin);
    run_walk(30, -1, '0);
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (got_rk[i] !== model_rk(i)) begin
        n_fail++;
        $display("FAIL bp_idx%0d: got %h, required %h", i, got_rk[i], model_rk(i));
      end
    end
  endtask

  task automatic test_load_busy();
    fwd_expand(FipsKey);
    load_key(FipsWin);
    run_walk(100, 9, ~FipsWin);
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (got_rk[i] !== model_rk(i)) begin
        n_fail++;
        $display("FAIL busy_idx%0d: got %h, required %h", i, got_rk[i], model_rk(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fwd_expand(FipsKey);
    load_key(FipsWin);
    cyc = 0;
    while (rk_idx_o !== 4'd6 && cyc < 20) begin
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      cyc++;
    end
    yumi_i = 1'b0;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    n_checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || rk_o !== 128'h0 || rk_idx_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b ready=%b rk=%h idx=%0d, required 0 1 0 0",
               v_o, ready_o, rk_o, rk_idx_o);
    end
    load_key(FipsWin);
    run_walk(100, -1, '0);
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (got_rk[i] !== model_rk(i)) begin
        n_fail++;
        $display("FAIL rst_reload_idx%0d: got %h, required %h", i, got_rk[i], model_rk(i));
      end
    end
  endtask

  task automatic test_zero_window();
    model_inv('0);
    load_key('0);
    run_walk(100, -1, '0);
    n_checks++;
    if (got_rk[12] !== {32'h23636363, 96'h0}) begin
      n_fail++;
      $display("FAIL zero_rk12: got %h, required %h", got_rk[12], {32'h23636363, 96'h0});
    end
    n_checks++;
    if (got_rk[11] !== {32'h63636363, 96'h0}) begin
      n_fail++;
      $display("FAIL zero_rk11: got %h, required %h", got_rk[11], {32'h63636363, 96'h0});
    end
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (got_rk[i] !== model_rk(i)) begin
        n_fail++;
        $display("FAIL zero_idx%0d: got %h, required %h", i, got_rk[i], model_rk(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_round_trip();
    test_backpressure();
    test_load_busy();
    test_reset_mid();
    test_zero_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
